// File: rtl/zedtc1_pkg.sv
// ----------------------------------------------------------------------------
// zedtc1_pkg : register map, clock-select codes and mode enum for the TC1 tile
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package zedtc1_pkg;

  localparam logic [2:0] C_ADDR_TCNTL  = 3'd0;
  localparam logic [2:0] C_ADDR_TCNTH  = 3'd1;
  localparam logic [2:0] C_ADDR_OCRAL  = 3'd2;
  localparam logic [2:0] C_ADDR_OCRAH  = 3'd3;
  localparam logic [2:0] C_ADDR_OCRBL  = 3'd4;
  localparam logic [2:0] C_ADDR_OCRBH  = 3'd5;
  localparam logic [2:0] C_ADDR_CTRL   = 3'd6;
  localparam logic [2:0] C_ADDR_STATUS = 3'd7;

  localparam logic [2:0] C_CS_STOP     = 3'd0;
  localparam logic [2:0] C_CS_DIV1     = 3'd1;
  localparam logic [2:0] C_CS_DIV8     = 3'd2;
  localparam logic [2:0] C_CS_DIV64    = 3'd3;
  localparam logic [2:0] C_CS_DIV256   = 3'd4;
  localparam logic [2:0] C_CS_DIV1024  = 3'd5;
  localparam logic [2:0] C_CS_EXT_RISE = 3'd6;
  localparam logic [2:0] C_CS_EXT_FALL = 3'd7;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_CTC      = 2'd1,
    MODE_PWM_MAX  = 2'd2,
    MODE_PWM_OCRA = 2'd3
  } mode_e;

  localparam int C_STAT_TOV  = 0;
  localparam int C_STAT_OCFA = 1;
  localparam int C_STAT_OCFB = 2;

  // Mode bit 1 selects PWM waveforms, bit 0 selects OCRA as TOP.
  function automatic logic mode_is_pwm(input mode_e m);
    return (m == MODE_PWM_MAX) || (m == MODE_PWM_OCRA);
  endfunction

  function automatic logic mode_top_is_ocra(input mode_e m);
    return (m == MODE_CTC) || (m == MODE_PWM_OCRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/zedtc1_prescaler.sv
// ----------------------------------------------------------------------------
// zedtc1_prescaler : free-running /1../1024 divider plus optional external
// clock edge detector (ZEDTC1_EXT_CLK_EN); emits a 1-cycle tick.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module zedtc1_prescaler
  import zedtc1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_i,
  input  logic [2:0] cs_i,
  input  logic       ext_i,
  output logic       tick_o
);

  logic [9:0] pre_q;
  logic       w_ext_rise;
  logic       w_ext_fall;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 10'd1;
    end
  end

`ifdef ZEDTC1_EXT_CLK_EN
  // [1:0] is the 2-flop synchronizer, [2] holds the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ext_i};
    end
  end

  assign w_ext_rise = sync_q[1] & ~sync_q[2];
  assign w_ext_fall = ~sync_q[1] & sync_q[2];
`else
  logic w_unused_ext;
  assign w_unused_ext = ext_i;
  assign w_ext_rise   = 1'b0;
  assign w_ext_fall   = 1'b0;
`endif

  always_comb begin
    tick_o = 1'b0;
    case (cs_i)
      C_CS_DIV1:     tick_o = 1'b1;
      C_CS_DIV8:     tick_o = &pre_q[2:0];
      C_CS_DIV64:    tick_o = &pre_q[5:0];
      C_CS_DIV256:   tick_o = &pre_q[7:0];
      C_CS_DIV1024:  tick_o = &pre_q[9:0];
      C_CS_EXT_RISE: tick_o = w_ext_rise;
      C_CS_EXT_FALL: tick_o = w_ext_fall;
      default:       tick_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/zedtc1_top.sv
// ----------------------------------------------------------------------------
// zedtc1_top : 16-bit timer/counter tile with two compare channels and IRQ.
// External clock select is built only with ZEDTC1_EXT_CLK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module zedtc1_top
  import zedtc1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] ocra_q, ocra_d;
  logic [15:0] ocrb_q, ocrb_d;
  logic [6:0]  ctrl_q, ctrl_d;
  logic [2:0]  flags_q, flags_d;
  logic        oca_q, oca_d;
  logic        ocb_q, ocb_d;

  logic        w_tick;
  logic        w_we;
  logic [2:0]  w_addr;
  mode_e       w_mode;
  logic [15:0] w_top;
  logic        w_at_top;
  logic        w_match_a;
  logic        w_match_b;
  logic        w_unused;

  assign w_we      = uio_in[3];
  assign w_addr    = uio_in[2:0];
  assign w_mode    = mode_e'(ctrl_q[4:3]);
  assign w_top     = mode_top_is_ocra(w_mode) ? ocra_q : 16'hFFFF;
  assign w_at_top  = (tcnt_q == w_top);
  assign w_match_a = (tcnt_q == ocra_q);
  assign w_match_b = (tcnt_q == ocrb_q);
  assign w_unused  = &{1'b0, ena, uio_in[7:5]};

  zedtc1_prescaler u_prescaler (
    .clk    (clk),
    .rst_i  (rst_n),
    .cs_i   (ctrl_q[2:0]),
    .ext_i  (uio_in[4]),
    .tick_o (w_tick)
  );

  always_comb begin
    tcnt_d  = tcnt_q;
    ocra_d  = ocra_q;
    ocrb_d  = ocrb_q;
    ctrl_d  = ctrl_q;
    flags_d = flags_q;
    oca_d   = oca_q;
    ocb_d   = ocb_q;

    if (w_tick) begin
      tcnt_d = w_at_top ? 16'h0000 : tcnt_q + 16'd1;
    end

    // A CPU write to a TCNT byte replaces the increment for this cycle.
    if (w_we) begin
      case (w_addr)
        C_ADDR_TCNTL:  tcnt_d  = {tcnt_q[15:8], ui_in};
        C_ADDR_TCNTH:  tcnt_d  = {ui_in, tcnt_q[7:0]};
        C_ADDR_OCRAL:  ocra_d  = {ocra_q[15:8], ui_in};
        C_ADDR_OCRAH:  ocra_d  = {ui_in, ocra_q[7:0]};
        C_ADDR_OCRBL:  ocrb_d  = {ocrb_q[15:8], ui_in};
        C_ADDR_OCRBH:  ocrb_d  = {ui_in, ocrb_q[7:0]};
        C_ADDR_CTRL:   ctrl_d  = ui_in[6:0];
        C_ADDR_STATUS: flags_d = flags_q & ~ui_in[2:0];
        default:       ;
      endcase
    end

    // Flag sets are applied after the clear so a simultaneous set wins.
    if (w_tick) begin
      if (w_at_top)  flags_d[C_STAT_TOV]  = 1'b1;
      if (w_match_a) flags_d[C_STAT_OCFA] = 1'b1;
      if (w_match_b) flags_d[C_STAT_OCFB] = 1'b1;
      if (mode_is_pwm(w_mode)) begin
        oca_d = (tcnt_d < ocra_q);
        ocb_d = (tcnt_d < ocrb_q);
      end else begin
        if (w_match_a) oca_d = ~oca_q;
        if (w_match_b) ocb_d = ~ocb_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tcnt_q  <= '0;
      ocra_q  <= '0;
      ocrb_q  <= '0;
      ctrl_q  <= '0;
      flags_q <= '0;
      oca_q   <= 1'b0;
      ocb_q   <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      ocra_q  <= ocra_d;
      ocrb_q  <= ocrb_d;
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
      oca_q   <= oca_d;
      ocb_q   <= ocb_d;
    end
  end

  always_comb begin
    uo_out = 8'h00;
    case (w_addr)
      C_ADDR_TCNTL:  uo_out = tcnt_q[7:0];
      C_ADDR_TCNTH:  uo_out = tcnt_q[15:8];
      C_ADDR_OCRAL:  uo_out = ocra_q[7:0];
      C_ADDR_OCRAH:  uo_out = ocra_q[15:8];
      C_ADDR_OCRBL:  uo_out = ocrb_q[7:0];
      C_ADDR_OCRBH:  uo_out = ocrb_q[15:8];
      C_ADDR_CTRL:   uo_out = {1'b0, ctrl_q};
      C_ADDR_STATUS: uo_out = {5'b00000, flags_q};
      default:       uo_out = 8'h00;
    endcase
  end

  assign uio_out = {|flags_q, ocb_q & ctrl_q[6], oca_q & ctrl_q[5], 5'b00000};
  assign uio_oe  = 8'hE0;

endmodule

`default_nettype wire

// File: tb/tb_zedtc1_top.sv
// ----------------------------------------------------------------------------
// tb_zedtc1_top : self-checking bench for the TC1 timer/counter tile
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_zedtc1_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [2:0] addr;
  logic       we;
  logic       ext;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  assign uio_in = {3'b000, ext, we, addr};

  always #5 clk = ~clk;

  zedtc1_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] tcnt;
    logic        oc;
  } sb_t;

  sb_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = uo_out;
  endtask

  task automatic rd16(output logic [15:0] v);
    logic [7:0] lo;
    logic [7:0] hi;
    rd(3'd0, lo);
    rd(3'd1, hi);
    v = {hi, lo};
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr  = a;
    ui_in = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t        regv[7];
    logic [7:0]  d;
    logic [15:0] v;
    logic [15:0] m;
    logic        oc;
    sb_t         e;
    int          highs;
    int          ext_inc;

    regv[0] = '{3'd2, 8'hA5, 8'hA5};
    regv[1] = '{3'd3, 8'h5A, 8'h5A};
    regv[2] = '{3'd4, 8'h3C, 8'h3C};
    regv[3] = '{3'd5, 8'hC3, 8'hC3};
    regv[4] = '{3'd6, 8'h80, 8'h00};
    regv[5] = '{3'd6, 8'h78, 8'h78};
    regv[6] = '{3'd7, 8'hFF, 8'h00};

    rst_n = 1'b1;
    addr  = 3'd0;
    we    = 1'b0;
    ext   = 1'b0;
    ui_in = 8'hA5;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      check($sformatf("reset_reg%0d", i), 32'(d), 32'h0);
    end
    check("reset_uio_out", 32'(uio_out), 32'h0);
    check("reset_uio_oe", 32'(uio_oe), 32'hE0);
    rst_n = 1'b0;
    @(negedge clk);

    // Register write/readback table
    for (int i = 0; i < 7; i++) begin
      wr(regv[i].addr, regv[i].wdata);
      rd(regv[i].addr, d);
      check($sformatf("regrw%0d", i), 32'(d), 32'(regv[i].exp));
    end

    // Normal mode /1
    do_reset();
    wr(3'd6, 8'h01);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      rd(3'd0, d);
      check($sformatf("norm_cnt%0d", i), 32'(d), 32'(i));
    end
    wr(3'd6, 8'h00);
    wr(3'd0, 8'hFE);
    wr(3'd1, 8'hFF);
    wr(3'd7, 8'hFF);
    wr(3'd6, 8'h01);
    @(negedge clk);
    rd16(v);
    check("norm_ffff", 32'(v), 32'hFFFF);
    rd(3'd7, d);
    check("norm_tov_pre", 32'(d), 32'h00);
    @(negedge clk);
    rd(3'd7, d);
    check("norm_tov_set", 32'(d), 32'h01);
    check("norm_irq", 32'(uio_out[7]), 32'h1);
    rd16(v);
    check("norm_wrap", 32'(v), 32'h0000);
    wr(3'd7, 8'h01);
    rd(3'd7, d);
    check("norm_tov_clr", 32'(d), 32'h06);

    // CPU write beats the increment
    wr(3'd0, 8'h50);
    rd16(v);
    check("wr_wins_lo", 32'(v), 32'h0050);
    @(negedge clk);
    rd16(v);
    check("wr_after_lo", 32'(v), 32'h0051);
    wr(3'd1, 8'h12);
    rd16(v);
    check("wr_wins_hi", 32'(v), 32'h1251);

    // OCRA=0 in CTC, simultaneous clear and set
    do_reset();
    wr(3'd6, 8'h09);
    @(negedge clk);
    rd(3'd7, d);
    check("ctc0_flags", 32'(d), 32'h07);
    rd16(v);
    check("ctc0_tcnt", 32'(v), 32'h0000);
    wr(3'd7, 8'hFF);
    rd(3'd7, d);
    check("set_wins", 32'(d), 32'h07);
    rd16(v);
    check("ctc0_tcnt2", 32'(v), 32'h0000);
    wr(3'd6, 8'h00);
    wr(3'd7, 8'hFF);
    rd(3'd7, d);
    check("w1c_stopped", 32'(d), 32'h00);

    // CTC with OCRA=3 and OCA enabled
    do_reset();
    wr(3'd2, 8'h03);
    wr(3'd6, 8'h29);
    m  = 16'd0;
    oc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (m == 16'd3) begin
        m  = 16'd0;
        oc = ~oc;
      end else begin
        m = m + 16'd1;
      end
      sb_q.push_back('{m, oc});
      @(negedge clk);
      rd16(v);
      e = sb_q.pop_front();
      check($sformatf("ctc_tcnt%0d", i), 32'(v), 32'(e.tcnt));
      check($sformatf("ctc_oca%0d", i), 32'(uio_out[5]), 32'(e.oc));
    end
    rd(3'd7, d);
    check("ctc_ocfa", 32'(d & 8'h02), 32'h02);

    // Prescaler /8
    do_reset();
    wr(3'd6, 8'h02);
    rd16(m);
    for (int k = 1; k <= 4; k++) begin
      repeat (8) @(negedge clk);
      rd16(v);
      check($sformatf("div8_win%0d", k), 32'(v), 32'(m + 16'(k)));
    end

    // Fast PWM, TOP=OCRA=9, OCRB=3, only OCB enabled
    do_reset();
    wr(3'd2, 8'h09);
    wr(3'd4, 8'h03);
    wr(3'd6, 8'h59);
    m     = 16'd0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      m  = (m == 16'd9) ? 16'd0 : m + 16'd1;
      oc = (m < 16'd3);
      sb_q.push_back('{m, oc});
      @(negedge clk);
      rd16(v);
      e = sb_q.pop_front();
      check($sformatf("pwm_tcnt%0d", i), 32'(v), 32'(e.tcnt));
      check($sformatf("pwm_ocb%0d", i), 32'(uio_out[6]), 32'(e.oc));
      check($sformatf("pwm_oca_off%0d", i), 32'(uio_out[5]), 32'h0);
      highs += int'(uio_out[6]);
    end
    check("pwm_duty", 32'(highs), 32'd6);
    wr(3'd4, 8'h00);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      highs += int'(uio_out[6]);
    end
    check("pwm_ocrb0", 32'(highs), 32'd0);

    // External clock, rising edges
`ifdef ZEDTC1_EXT_CLK_EN
    ext_inc = 1;
`else
    ext_inc = 0;
`endif
    do_reset();
    wr(3'd6, 8'h06);
    ext = 1'b1;
    @(negedge clk);
    rd16(v);
    check("ext_lat1", 32'(v), 32'h0);
    @(negedge clk);
    rd16(v);
    check("ext_lat2", 32'(v), 32'h0);
    @(negedge clk);
    rd16(v);
    check("ext_lat3", 32'(v), 32'(ext_inc));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ext = 1'b0;
      repeat (4) @(negedge clk);
      ext = 1'b1;
      repeat (4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rd16(v);
    check("ext_count", 32'(v), 32'(4 * ext_inc));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zedtc1_top.md
# zedtc1_top

16-bit timer/counter peripheral (TC1) built as a Tiny Tapeout user tile. An 8-bit register file is written through `ui_in` and addressed and strobed through `uio_in[3:0]`. A combinational readback mux drives `uo_out`. The block provides a 16-bit counter, a 10-bit prescaler, two compare channels (A/B) with waveform outputs, status flags and an IRQ line on the upper `uio` pins.

## Interface
No parameters.

Ports:
- `clk` input 1: single clock; all state is on its rising edge.
- `rst_n` input 1: reset is asynchronous and active-high. Port name follows the harness convention; reset is asserted when `rst_n`=1.
- `ena` input 1: ignored; the block always runs.
- `ui_in` input 8: write data.
- `uio_in` input 8:
  - [2:0] register address
  - [3] write enable (level; one write per clock while high)
  - [4] external clock input
  - [7:5] unused
- `uo_out` output 8: readback of the register at `uio_in[2:0]`, combinational.
- `uio_out` output 8: [5] OCA, [6] OCB, [7] IRQ, [4:0] = 0.
- `uio_oe` output 8: constant 8'hE0.

## Operation
Registers (address: name), all reset to 0:
- 0: TCNT[7:0]; 1: TCNT[15:8]
- 2: OCRA[7:0]; 3: OCRA[15:8]
- 4: OCRB[7:0]; 5: OCRB[15:8]
- 6: CTRL — [2:0] CS, [4:3] MODE, [5] OCA_EN, [6] OCB_EN, [7] reserved (reads 0)
- 7: STATUS — [0] TOV, [1] OCFA, [2] OCFB; write-1-to-clear; [7:3] read 0

Prescaler clock select (CS):
- 0: stop
- 1: /1
- 2: /8
- 3: /64
- 4: /256
- 5: /1024
- 6: external rising edge
- 7: external falling edge
- The 10-bit prescaler counter free-runs from reset. A /N tick occurs when its low log2(N) bits are all ones.

MODE:
- 0 Normal: TOP=16'hFFFF.
- 1 CTC: TOP=OCRA.
- 2 Fast PWM: TOP=16'hFFFF.
- 3 Fast PWM: TOP=OCRA.

On a tick:
- If TCNT==TOP, TCNT←0 and TOV←1; otherwise TCNT←TCNT+1.
- Also OCFA←1 if TCNT==OCRA, and OCFB←1 if TCNT==OCRB, both evaluated on the pre-update TCNT.

Waveform outputs:
- Modes 0/1: OCx toggles on its match tick.
- Modes 2/3: OCx ← (TCNT_next < OCRx). OCRx=0 gives constant 0.
- OCx_EN=0 forces the pin to 0; the internal toggle state still runs.

IRQ = TOV | OCFA | OCFB.

Boundaries:
- CPU write to either TCNT byte in a tick cycle: the write wins and no increment occurs.
- STATUS clear and flag set in the same cycle: set wins.
- OCRA=0 in mode 1/3: TCNT stays 0, TOV and OCFA set on every tick.
- Changing CS or MODE mid-count takes effect on the next cycle; TCNT is not cleared.
- Reset mid-operation clears all state immediately, including the prescaler and synchronizer.

## Timing
- Register writes land on the clock edge where `uio_in[3]`=1.
- Counter update, flags and OCx are all registered: visible one clock after the tick cycle.
- External clock path: 2-flop synchronizer plus edge detect. A tick occurs 3 clocks after the pin edge. The input must be stable ≥2 clocks per level.
- `uo_out` has zero latency after an address change.
- Reset values: `uo_out`=0, `uio_out`=0, `uio_oe`=8'hE0.

## Configuration
- `ZEDTC1_EXT_CLK_EN` defined: CS 6/7 count external edges; the synchronizer is present.
- `ZEDTC1_EXT_CLK_EN` undefined: CS 6/7 behave as stop, the synchronizer is omitted and `uio_in[4]` is ignored.

## Structure
- Package `zedtc1_pkg` holds:
  - register address constants
  - CS encodings
  - MODE enum
  - STATUS bit indices
- Sub-module `zedtc1_prescaler` takes `clk`, reset, CS and the external pin, and produces a 1-cycle `tick`.
- The top level holds the register file, counter, compare logic and readback mux.

## Test plan
- Reset check: assert reset → `uo_out`=0 for addresses 0–7, `uio_out`=0, `uio_oe`=8'hE0.
- Normal /1 count: CS=1, MODE=0 → TCNT reads 1,2,3 on consecutive clocks. Preload TCNT=16'hFFFE → TOV=1 and IRQ=1 two ticks later. Write STATUS=8'h01 → TOV=0.
- CTC: OCRA=3, MODE=1, CS=1 → TCNT sequence 0,1,2,3,0. OCFA sets, and OCA (enabled) toggles every 4 clocks.
- Prescaler /8: CS=2 → TCNT advances exactly once per 8 clocks.
- Fast PWM: MODE=3, OCRA=9, OCRB=3, OCB_EN=1 → OCB high 3 of every 10 clocks. OCRB=0 → OCB constant 0.
- External clock (macro on): CS=6, toggle `uio_in[4]` every 4 clocks → one increment per rising edge, 3-clock latency. Macro off: TCNT stays constant.
